// File: rtl/exc_commit_ctrl_pkg.sv
// Shared encodings for precise-exception commit: CP0 ExcCodes, FSM states, default vector.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_ERET = 5'd14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_REDIR  = 2'd3;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
  } exc_lat_t;

  // Pipeline type word -> stored code; 1 stays as the interrupt marker, unknowns become RI.
  function automatic logic [4:0] exc_norm(input logic [4:0] c);
    case (c)
      5'h01, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h0e: exc_norm = c;
      default: exc_norm = EXC_RI;
    endcase
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// MEM-stage / CP0 / redirect bundle for exc_commit_ctrl. wdog_err exists only with EXC_WDOG_EN.
interface exc_commit_ctrl_if;
  logic        valid_m;
  logic [31:0] excepttype_m;
  logic [31:0] pc_m;
  logic        in_delayslot_m;
  logic [31:0] bad_addr_m;
  logic        mem_busy;
  logic [31:0] cp0_epc;
  logic        stall_req;
  logic        flush_all;
  logic        newpc_valid;
  logic [31:0] newpc;
  logic        cp0_exc_we;
  logic [4:0]  cp0_exccode;
  logic        cp0_bd;
  logic [31:0] cp0_epc_wdata;
  logic        cp0_badvaddr_we;
  logic [31:0] cp0_badvaddr;
  logic        cp0_eret;
  logic        busy;
`ifdef EXC_WDOG_EN
  logic        wdog_err;
`endif

  modport master (
    output valid_m, excepttype_m, pc_m, in_delayslot_m, bad_addr_m, mem_busy, cp0_epc,
    input  stall_req, flush_all, newpc_valid, newpc, cp0_exc_we, cp0_exccode, cp0_bd,
           cp0_epc_wdata, cp0_badvaddr_we, cp0_badvaddr, cp0_eret, busy
`ifdef EXC_WDOG_EN
    , input wdog_err
`endif
  );

  modport slave (
    input  valid_m, excepttype_m, pc_m, in_delayslot_m, bad_addr_m, mem_busy, cp0_epc,
    output stall_req, flush_all, newpc_valid, newpc, cp0_exc_we, cp0_exccode, cp0_bd,
           cp0_epc_wdata, cp0_badvaddr_we, cp0_badvaddr, cp0_eret, busy
`ifdef EXC_WDOG_EN
    , output wdog_err
`endif
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Precise-exception commit sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT.
// Optional drain watchdog with sticky wdog_err under macro EXC_WDOG_EN.
module exc_commit_ctrl import exc_pkg::*; #(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [31:0] excepttype_m,
  input  logic [31:0] pc_m,
  input  logic        in_delayslot_m,
  input  logic [31:0] bad_addr_m,
  input  logic        mem_busy,
  input  logic [31:0] cp0_epc,
  output logic        stall_req,
  output logic        flush_all,
  output logic        newpc_valid,
  output logic [31:0] newpc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic [31:0] cp0_epc_wdata,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret,
  output logic        busy
`ifdef EXC_WDOG_EN
  , output logic      wdog_err
`endif
);

  logic [1:0]  st, st_nxt;
  exc_lat_t    lat;
  logic        trig, in_commit, in_redir, is_eret, wdog_hit;
  logic [4:0]  c_exccode, h_exccode;
  logic [31:0] c_epc, h_epc, h_bva, r_newpc, h_newpc;
  logic        h_bd;

  assign trig      = (st == ST_IDLE) && valid_m && (excepttype_m != 32'd0);
  assign in_commit = (st == ST_COMMIT);
  assign in_redir  = (st == ST_REDIR);
  assign is_eret   = (lat.code == EXC_ERET);
  assign c_exccode = (lat.code == 5'h01) ? EXC_INT : lat.code;
  assign c_epc     = lat.ds ? lat.pc - 32'd4 : lat.pc;
  assign r_newpc   = is_eret ? cp0_epc : EXC_VECTOR;

`ifdef EXC_WDOG_EN
  logic [8:0] wcnt;
  logic       wdog_err_q;

  assign wdog_hit = (st == ST_DRAIN) && mem_busy && (wcnt + 9'd1 == WDOG_CYCLES[8:0]);
  assign wdog_err = wdog_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt       <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wcnt <= (st == ST_DRAIN) ? wcnt + 9'd1 : 9'd0;
      if (wdog_hit) wdog_err_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:   if (trig) st_nxt = mem_busy ? ST_DRAIN : ST_COMMIT;
      ST_DRAIN:  if (!mem_busy || wdog_hit) st_nxt = ST_COMMIT;
      ST_COMMIT: st_nxt = ST_REDIR;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      lat       <= '0;
      h_exccode <= '0;
      h_bd      <= 1'b0;
      h_epc     <= '0;
      h_bva     <= '0;
      h_newpc   <= '0;
    end else begin
      st <= st_nxt;
      if (trig) begin
        lat.code <= exc_norm(excepttype_m[4:0]);
        lat.pc   <= pc_m;
        lat.ds   <= in_delayslot_m;
        lat.bad  <= bad_addr_m;
      end
      if (in_commit) begin
        h_exccode <= c_exccode;
        h_bd      <= lat.ds;
        h_epc     <= c_epc;
        h_bva     <= lat.bad;
      end
      if (in_redir) h_newpc <= r_newpc;
    end
  end

  assign stall_req       = trig || (st == ST_DRAIN) || in_commit;
  assign flush_all       = in_redir;
  assign newpc_valid     = in_redir;
  assign newpc           = in_redir ? r_newpc : h_newpc;
  assign cp0_exc_we      = in_commit && !is_eret;
  assign cp0_eret        = in_commit && is_eret;
  assign cp0_exccode     = in_commit ? c_exccode : h_exccode;
  assign cp0_bd          = in_commit ? lat.ds : h_bd;
  assign cp0_epc_wdata   = in_commit ? c_epc : h_epc;
  assign cp0_badvaddr_we = in_commit && (lat.code == EXC_ADEL || lat.code == EXC_ADES);
  assign cp0_badvaddr    = in_commit ? lat.bad : h_bva;
  assign busy            = (st != ST_IDLE);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: timeline model checked every cycle plus literal pins.
module tb_exc_commit_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int WD = 4;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl_if bus();

  exc_commit_ctrl #(.WDOG_CYCLES(WD)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_m         (bus.valid_m),
    .excepttype_m    (bus.excepttype_m),
    .pc_m            (bus.pc_m),
    .in_delayslot_m  (bus.in_delayslot_m),
    .bad_addr_m      (bus.bad_addr_m),
    .mem_busy        (bus.mem_busy),
    .cp0_epc         (bus.cp0_epc),
    .stall_req       (bus.stall_req),
    .flush_all       (bus.flush_all),
    .newpc_valid     (bus.newpc_valid),
    .newpc           (bus.newpc),
    .cp0_exc_we      (bus.cp0_exc_we),
    .cp0_exccode     (bus.cp0_exccode),
    .cp0_bd          (bus.cp0_bd),
    .cp0_epc_wdata   (bus.cp0_epc_wdata),
    .cp0_badvaddr_we (bus.cp0_badvaddr_we),
    .cp0_badvaddr    (bus.cp0_badvaddr),
    .cp0_eret        (bus.cp0_eret),
    .busy            (bus.busy)
`ifdef EXC_WDOG_EN
    , .wdog_err      (bus.wdog_err)
`endif
  );

  int          cyc = 0;
  bit          m_act = 0;
  int          t_trig = 0;
  int          t_commit = -1;
  logic [4:0]  m_code = '0;
  logic [31:0] m_pc = '0, m_bad = '0;
  logic        m_ds = 1'b0;
  logic [4:0]  x_code = '0;
  logic        x_bd = 1'b0;
  logic [31:0] x_epc = '0, x_bva = '0, x_newpc = '0;
  bit          x_wd = 0;

  always @(negedge clk) begin : mdl
    logic [109:0] e, a;
    logic [4:0]   cc;
    logic [31:0]  rpc;
    logic         a_wd;
    bit trg, in_c, in_r, in_d;
    trg  = !m_act && bus.valid_m && (bus.excepttype_m != 32'd0);
    in_c = m_act && (t_commit == cyc);
    in_r = m_act && (t_commit >= 0) && (cyc == t_commit + 1);
    in_d = m_act && !in_c && !in_r;
    cc   = (m_code == 5'd1) ? 5'd0 : m_code;
    rpc  = (m_code == 5'd14) ? bus.cp0_epc : VEC;
`ifdef EXC_WDOG_EN
    a_wd = bus.wdog_err;
`else
    a_wd = 1'b0;
`endif
    if (!rst) begin
      e = {x_wd, trg || in_d || in_c, in_r, in_r, in_r ? rpc : x_newpc,
           in_c && m_code != 5'd14, in_c ? cc : x_code, in_c ? m_ds : x_bd,
           in_c ? (m_ds ? m_pc - 32'd4 : m_pc) : x_epc,
           in_c && (m_code == 5'd4 || m_code == 5'd5), in_c ? m_bad : x_bva,
           in_c && m_code == 5'd14, m_act};
      a = {a_wd, bus.stall_req, bus.flush_all, bus.newpc_valid, bus.newpc,
           bus.cp0_exc_we, bus.cp0_exccode, bus.cp0_bd, bus.cp0_epc_wdata,
           bus.cp0_badvaddr_we, bus.cp0_badvaddr, bus.cp0_eret, bus.busy};
      nvec++;
      if (a !== e) begin
        nmis++;
        $display("FAIL cycle %0d outputs: got %h expected %h", cyc, a, e);
      end
    end
    if (rst) begin
      m_act = 0; t_commit = -1; x_wd = 0;
      x_code = '0; x_bd = 1'b0; x_epc = '0; x_bva = '0; x_newpc = '0;
    end else begin
      if (in_c) begin
        x_code = cc; x_bd = m_ds; x_epc = m_ds ? m_pc - 32'd4 : m_pc; x_bva = m_bad;
      end
      if (in_r) begin
        x_newpc = rpc; m_act = 0;
      end
      if (in_d) begin
        if (!bus.mem_busy) t_commit = cyc + 1;
`ifdef EXC_WDOG_EN
        else if (cyc - t_trig == WD) begin
          t_commit = cyc + 1; x_wd = 1;
        end
`endif
      end
      if (trg) begin
        m_act  = 1;
        t_trig = cyc;
        t_commit = bus.mem_busy ? -1 : cyc + 1;
        m_code = bus.excepttype_m[4:0];
        if (!(m_code inside {5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd14})) m_code = 5'd10;
        m_pc = bus.pc_m; m_ds = bus.in_delayslot_m; m_bad = bus.bad_addr_m;
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bus.valid_m = 1'b0; bus.excepttype_m = '0; bus.pc_m = '0;
    bus.in_delayslot_m = 1'b0; bus.bad_addr_m = '0; bus.mem_busy = 1'b0;
  endtask

  task automatic fire(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                      input logic [31:0] bad, input logic mb);
    bus.valid_m = 1'b1; bus.excepttype_m = t; bus.pc_m = pc;
    bus.in_delayslot_m = ds; bus.bad_addr_m = bad; bus.mem_busy = mb;
  endtask

  initial begin
    rst = 1'b1; quiet(); bus.cp0_epc = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_strobes", {26'd0, bus.stall_req, bus.flush_all, bus.newpc_valid,
        bus.cp0_exc_we, bus.cp0_badvaddr_we, bus.cp0_eret}, 32'd0);
    chk("reset_newpc", bus.newpc, 32'd0);

    step(); fire(32'hc, 32'h80001000, 1'b0, 32'h0, 1'b0);
    @(negedge clk); chk("ov_trig_stall", {31'd0, bus.stall_req}, 32'd1);
    step(); quiet();
    @(negedge clk);
    chk("ov_exc_we", {31'd0, bus.cp0_exc_we}, 32'd1);
    chk("ov_exccode", {27'd0, bus.cp0_exccode}, 32'd12);
    chk("ov_epc", bus.cp0_epc_wdata, 32'h80001000);
    chk("ov_bd_bvwe", {30'd0, bus.cp0_bd, bus.cp0_badvaddr_we}, 32'd0);
    step();
    @(negedge clk);
    chk("ov_flush", {31'd0, bus.flush_all}, 32'd1);
    chk("ov_newpc", bus.newpc, 32'hBFC00380);
    step(); step();

    fire(32'h5, 32'h80002004, 1'b1, 32'h10000003, 1'b1);
    step(); bus.valid_m = 1'b0;
    step();
    step(); bus.mem_busy = 1'b0;
    @(negedge clk); chk("ds_drain_nowe", {30'd0, bus.stall_req, bus.cp0_exc_we}, 32'd2);
    step();
    @(negedge clk);
    chk("ds_epc", bus.cp0_epc_wdata, 32'h80002000);
    chk("ds_bd_bvwe", {30'd0, bus.cp0_bd, bus.cp0_badvaddr_we}, 32'd3);
    chk("ds_badvaddr", bus.cp0_badvaddr, 32'h10000003);
    step(); quiet(); step(); step();

    bus.cp0_epc = 32'h80003000;
    fire(32'he, 32'h80004000, 1'b0, 32'h0, 1'b0);
    step(); quiet();
    @(negedge clk); chk("eret_strobes", {30'd0, bus.cp0_eret, bus.cp0_exc_we}, 32'd2);
    step();
    @(negedge clk); chk("eret_newpc", bus.newpc, 32'h80003000);
    step(); step();

    fire(32'h1, 32'h80005000, 1'b0, 32'h0, 1'b0);
    step(); fire(32'h8, 32'h80006000, 1'b0, 32'h0, 1'b0);
    @(negedge clk); chk("int_exccode", {27'd0, bus.cp0_exccode}, 32'd0);
    step();
    @(negedge clk); chk("int_flush", {31'd0, bus.flush_all}, 32'd1);
    step();
    @(negedge clk); chk("sys_accept", {30'd0, bus.stall_req, bus.busy}, 32'd2);
    step(); quiet();
    @(negedge clk); chk("sys_exccode", {27'd0, bus.cp0_exccode}, 32'd8);
    step(); step(); step();

    fire(32'h3, 32'h80007000, 1'b0, 32'h0, 1'b0);
    step(); quiet();
    @(negedge clk); chk("unk_exccode", {27'd0, bus.cp0_exccode}, 32'd10);
    step(); step(); step();

    fire(32'h8, 32'h80008000, 1'b0, 32'h0, 1'b1);
    step(); bus.valid_m = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0; quiet();
    @(negedge clk);
    chk("rstdrain_busy", {30'd0, bus.busy, bus.flush_all}, 32'd0);
    chk("rstdrain_epc", bus.cp0_epc_wdata, 32'd0);
    chk("rstdrain_code", {27'd0, bus.cp0_exccode}, 32'd0);
    step(); step(); step();

`ifdef EXC_WDOG_EN
    fire(32'h4, 32'h80009000, 1'b0, 32'h1234, 1'b1);
    step(); bus.valid_m = 1'b0;
    step(); step(); step();
    @(negedge clk); chk("wd_still_drain", {31'd0, bus.cp0_exc_we}, 32'd0);
    step();
    @(negedge clk); chk("wd_commit", {30'd0, bus.cp0_exc_we, bus.wdog_err}, 32'd3);
    step(); step(); bus.mem_busy = 1'b0; step();
    @(negedge clk); chk("wd_sticky", {31'd0, bus.wdog_err}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk); chk("wd_cleared", {31'd0, bus.wdog_err}, 32'd0);
    step(); step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences precise-exception commit for the MIPS pipeline.
- Takes the MEM-stage exception type word, waits for outstanding AXI data transactions to drain, then issues CP0 update strobes and a one-cycle pipeline flush with the redirect PC.
- Sits between the MEM-stage exception encoder, the CP0 register file, hazard/flush logic and the PC mux.
- Handles ERET: redirects to EPC and clears EXL.

Parameters:
- EXC_VECTOR, 32'hBFC00380, target PC for every exception other than ERET.
- WDOG_CYCLES, 255, drain-watchdog limit; used only with EXC_WDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_m  in  1  MEM-stage instruction valid (not a bubble)
- excepttype_m  in  32  exception type word: 0 none, 1 int, 4 adel, 5 ades, 8 sys, 9 bp, a ri, c ov, e eret
- pc_m  in  32  PC of the MEM-stage instruction
- in_delayslot_m  in  1  MEM-stage instruction is in a delay slot
- bad_addr_m  in  32  faulting address for adel/ades
- mem_busy  in  1  AXI data transaction outstanding
- cp0_epc  in  32  current EPC, the ERET target
- stall_req  out  1  freeze pipeline while the sequence is active
- flush_all  out  1  one-cycle flush of IF..WB
- newpc_valid  out  1  one-cycle PC redirect strobe
- newpc  out  32  redirect target
- cp0_exc_we  out  1  one-cycle strobe: write Cause.ExcCode/BD, EPC, set Status.EXL
- cp0_exccode  out  5  ExcCode value
- cp0_bd  out  1  Cause.BD value
- cp0_epc_wdata  out  32  EPC value
- cp0_badvaddr_we  out  1  one-cycle BadVAddr write strobe
- cp0_badvaddr  out  32  BadVAddr value
- cp0_eret  out  1  one-cycle strobe: clear Status.EXL
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM to IDLE; every output 0; latched registers 0. A reset in any state aborts the sequence with no CP0 strobe and no redirect.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - Trigger = valid_m && excepttype_m != 0.
  - On trigger, latch excepttype_m[4:0], pc_m, in_delayslot_m, bad_addr_m.
  - Go to DRAIN if mem_busy, else COMMIT.
  - stall_req is combinationally 1 in the trigger cycle.
- DRAIN: stall_req=1. Stay while mem_busy; go to COMMIT in the first cycle mem_busy=0.
- COMMIT (one cycle), stall_req=1:
  - Latched code 0xe: cp0_eret=1, cp0_exc_we=0.
  - Otherwise: cp0_exc_we=1; cp0_exccode = 0 for int, else the latched code.
  - cp0_bd = latched delay-slot flag.
  - cp0_epc_wdata = latched pc - 4 if delay slot, else latched pc (32-bit wrap).
  - cp0_badvaddr_we=1 only for codes 4/5; cp0_badvaddr = latched bad_addr.
- REDIRECT (one cycle):
  - flush_all=1, newpc_valid=1, stall_req=0.
  - newpc = cp0_epc sampled this cycle for ERET (reflects the COMMIT write path), else EXC_VECTOR.
  - Next state IDLE.
- Latency with mem_busy=0: trigger at cycle T, COMMIT at T+1, REDIRECT at T+2.
- Outside their states, all strobes are 0 and data outputs hold their last value.
- Triggers while busy=1 are ignored; the pipeline is stalled, so the same instruction is not re-sampled.
- A trigger in the cycle after REDIRECT is accepted normally, e.g. an interrupt pending at the handler entry.
- Unknown code (not 1,4,5,8,9,a,c,e): treated as RI (0xa).

Optional Feature:
- Macro EXC_WDOG_EN.
- Defined:
  - An 8+ bit counter increments each DRAIN cycle and clears on leaving DRAIN.
  - When it reaches WDOG_CYCLES, the FSM forces COMMIT regardless of mem_busy.
  - Sticky output wdog_err (1 bit, extra port) is set; only rst clears it.
- Undefined: no counter, no port; DRAIN waits indefinitely.

Decomposition:
- Shared package exc_pkg holds:
  - ExcCode localparams: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12, EXC_ERET=14.
  - State encoding.
  - Default EXC_VECTOR.
- No sub-module is natural; the watchdog counter stays inline.

Test Plan:
- Overflow: excepttype_m=0xc, pc_m=0x80001000, mem_busy=0 -> T+1: cp0_exc_we=1, exccode=12, epc_wdata=0x80001000, bd=0, badvaddr_we=0 -> T+2: flush_all=1, newpc=0xBFC00380.
- Delay slot with drain: excepttype_m=0x5, pc_m=0x80002004, in_delayslot=1, bad_addr=0x10000003, mem_busy high 3 cycles -> COMMIT at T+4 with epc=0x80002000, bd=1, badvaddr_we=1, badvaddr=0x10000003.
- ERET: excepttype_m=0xe, cp0_epc=0x80003000 -> T+1: cp0_eret=1, cp0_exc_we=0 -> T+2: newpc=0x80003000.
- Interrupt code 0x1 -> exccode=0; second trigger (0x8) held on inputs while busy -> ignored; accepted at REDIRECT+1.
- Reset asserted in DRAIN -> next cycle all outputs 0, busy=0, no flush issued.
- With EXC_WDOG_EN, WDOG_CYCLES=4, mem_busy stuck 1 -> COMMIT after 4 DRAIN cycles, wdog_err=1 until rst.
